// File: rtl/game_status_ctrl.sv
// Game-state FSM for the board: drives the playing/not-playing LED level,
// tracks lives, applies a post-hit invulnerability window and a game-over hold.
module game_status_ctrl #(
  parameter int LIVES         = 3,
  parameter int LIVES_W       = 4,
  parameter int INVULN_CYCLES = 50_000_000,
  parameter int HOLD_CYCLES   = 100_000_000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               hit,
  output logic               game_status,
  output logic [LIVES_W-1:0] lives,
  output logic               invuln,
  output logic               game_over_pulse,
  output logic [1:0]         state
);

  localparam int INV_W  = (INVULN_CYCLES > 1) ? $clog2(INVULN_CYCLES) : 1;
  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_PLAY = 2'b01,
    S_OVER = 2'b10
  } state_t;

  // start and hit are single-cycle pulses; each is acted on at the edge that samples it.
  state_t              state_q, state_d;
  logic                status_q, status_d;
  logic [LIVES_W-1:0]  lives_q, lives_d;
  logic                invuln_q, invuln_d;
  logic [INV_W-1:0]    inv_cnt_q, inv_cnt_d;
  logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
  logic                hold_done_q, hold_done_d;
  logic                gop_q, gop_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      status_q    <= 1'b0;
      lives_q     <= LIVES_W'(LIVES);
      invuln_q    <= 1'b0;
      inv_cnt_q   <= '0;
      hold_cnt_q  <= '0;
      hold_done_q <= 1'b0;
      gop_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      status_q    <= status_d;
      lives_q     <= lives_d;
      invuln_q    <= invuln_d;
      inv_cnt_q   <= inv_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
      hold_done_q <= hold_done_d;
      gop_q       <= gop_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    status_d    = status_q;
    lives_d     = lives_q;
    invuln_d    = invuln_q;
    inv_cnt_d   = inv_cnt_q;
    hold_cnt_d  = hold_cnt_q;
    hold_done_d = hold_done_q;
    gop_d       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_PLAY;
          status_d  = 1'b1;
          lives_d   = LIVES_W'(LIVES);
          invuln_d  = 1'b0;
          inv_cnt_d = '0;
        end
      end
      S_PLAY: begin
        // While invulnerable every hit is dropped, including the final counter cycle.
        if (invuln_q) begin
          if (inv_cnt_q == '0) invuln_d = 1'b0;
          else                 inv_cnt_d = inv_cnt_q - 1'b1;
        end else if (hit) begin
          if (lives_q > LIVES_W'(1)) begin
            lives_d   = lives_q - 1'b1;
            invuln_d  = 1'b1;
            inv_cnt_d = INV_W'(INVULN_CYCLES - 1);
          end else begin
            state_d     = S_OVER;
            status_d    = 1'b0;
            lives_d     = '0;
            invuln_d    = 1'b0;
            gop_d       = 1'b1;
            hold_cnt_d  = HOLD_W'(HOLD_CYCLES - 1);
            hold_done_d = 1'b0;
          end
        end
      end
      S_OVER: begin
        if (start && hold_done_q) begin
          state_d     = S_PLAY;
          status_d    = 1'b1;
          lives_d     = LIVES_W'(LIVES);
          invuln_d    = 1'b0;
          inv_cnt_d   = '0;
          hold_done_d = 1'b0;
        end else if (hold_cnt_q == '0) begin
          hold_done_d = 1'b1;
        end else begin
          hold_cnt_d = hold_cnt_q - 1'b1;
        end
      end
      default: begin
        state_d     = S_IDLE;
        status_d    = 1'b0;
        lives_d     = LIVES_W'(LIVES);
        invuln_d    = 1'b0;
        inv_cnt_d   = '0;
        hold_cnt_d  = '0;
        hold_done_d = 1'b0;
      end
    endcase
  end

  assign game_status     = status_q;
  assign lives           = lives_q;
  assign invuln          = invuln_q;
  assign game_over_pulse = gop_q;
  assign state           = state_q;

endmodule

// File: tb/tb_game_status_ctrl.sv
// Directed bench for game_status_ctrl with short counters (INVULN=4, HOLD=8).
module tb_game_status_ctrl;

  logic       clk;
  logic       rst;
  logic       start;
  logic       hit;
  logic       game_status;
  logic [3:0] lives;
  logic       invuln;
  logic       game_over_pulse;
  logic [1:0] state;

  int n_cmp = 0;
  int n_mis = 0;

  game_status_ctrl #(
    .LIVES(3), .LIVES_W(4), .INVULN_CYCLES(4), .HOLD_CYCLES(8)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .hit(hit),
    .game_status(game_status), .lives(lives), .invuln(invuln),
    .game_over_pulse(game_over_pulse), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Outputs settle 1 time unit after the active edge; inputs change there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_hit();
    hit = 1'b1; tick(); hit = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; hit = 1'b0;
    #3;
    check_eq("rst_state", state, 2'b00);
    check_eq("rst_status", game_status, 1'b0);
    check_eq("rst_lives", lives, 4'd3);
    check_eq("rst_invuln", invuln, 1'b0);
    check_eq("rst_gop", game_over_pulse, 1'b0);
    tick();
    rst = 1'b0;

    // IDLE: hits ignored, then start
    pulse_hit();
    check_eq("idle_hit_state", state, 2'b00);
    check_eq("idle_hit_lives", lives, 4'd3);
    tick(); tick();
    pulse_start();
    check_eq("start_state", state, 2'b01);
    check_eq("start_status", game_status, 1'b1);
    check_eq("start_lives", lives, 4'd3);
    check_eq("start_invuln", invuln, 1'b0);
    tick();

    // Non-fatal hit at T, invuln window T+1..T+4
    pulse_hit();                                   // T+1
    check_eq("hit1_lives", lives, 4'd2);
    check_eq("hit1_invuln", invuln, 1'b1);
    pulse_hit();                                   // T+2
    check_eq("inv_hit2_lives", lives, 4'd2);
    check_eq("inv_hit2_invuln", invuln, 1'b1);
    tick();                                        // T+3
    check_eq("inv_t3_invuln", invuln, 1'b1);
    pulse_hit();                                   // T+4
    check_eq("inv_hit4_lives", lives, 4'd2);
    check_eq("inv_t4_invuln", invuln, 1'b1);
    pulse_hit();                                   // T+5, counter read 0
    check_eq("inv_end_lives", lives, 4'd2);
    check_eq("inv_end_invuln", invuln, 1'b0);

    // Second hit, wait out window, fatal hit
    pulse_hit();
    check_eq("hit2_lives", lives, 4'd1);
    check_eq("hit2_invuln", invuln, 1'b1);
    repeat (4) tick();
    check_eq("hit2_win_end", invuln, 1'b0);
    check_eq("hit2_gop_low", game_over_pulse, 1'b0);
    pulse_hit();                                   // entry edge E
    check_eq("fatal_state", state, 2'b10);
    check_eq("fatal_status", game_status, 1'b0);
    check_eq("fatal_lives", lives, 4'd0);
    check_eq("fatal_gop", game_over_pulse, 1'b1);
    check_eq("fatal_invuln", invuln, 1'b0);
    tick();                                        // E+1
    check_eq("gop_one_cycle", game_over_pulse, 1'b0);
    check_eq("over_hold_state", state, 2'b10);

    // OVER: early starts ignored, start after hold accepted
    tick();                                        // E+2
    pulse_start();                                 // E+3
    check_eq("early_start_state", state, 2'b10);
    check_eq("over_lives", lives, 4'd0);
    pulse_hit();                                   // E+4
    check_eq("over_hit_state", state, 2'b10);
    repeat (3) tick();                             // E+7
    pulse_start();                                 // E+8, hold not yet done
    check_eq("late_early_start", state, 2'b10);
    pulse_start();                                 // E+9
    check_eq("restart_state", state, 2'b01);
    check_eq("restart_lives", lives, 4'd3);
    check_eq("restart_status", game_status, 1'b1);
    check_eq("restart_invuln", invuln, 1'b0);

    // Reach lives=1, invuln=1, then async reset mid-cycle
    pulse_hit();
    repeat (4) tick();
    pulse_hit();
    check_eq("pre_rst_lives", lives, 4'd1);
    check_eq("pre_rst_invuln", invuln, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check_eq("async_rst_state", state, 2'b00);
    check_eq("async_rst_lives", lives, 4'd3);
    check_eq("async_rst_invuln", invuln, 1'b0);
    check_eq("async_rst_status", game_status, 1'b0);
    tick();
    rst = 1'b0;

    // Simultaneous start + hit in IDLE
    start = 1'b1; hit = 1'b1;
    tick();
    start = 1'b0; hit = 1'b0;
    check_eq("sim_sh_state", state, 2'b01);
    check_eq("sim_sh_lives", lives, 4'd3);
    check_eq("sim_sh_invuln", invuln, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #20000;
    n_mis++;
    $display("FAIL timeout: got no finish expected finish by 20000");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
